// File: rtl/joy_db15_responder.sv
`default_nettype none
// ============================================================================
// joy_db15_responder : device-side DB15 joystick shift chain ('165 emulation)
// Optional input debounce: define JOY_DB15_RESPONDER_FILTER_EN.  Rev 1.0
// ============================================================================
module joy_db15_responder #(
  parameter int BITS     = 12,
  parameter int FILT_LEN = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_joy_clk,
  input  logic            i_joy_load,
  output logic            o_joy_data,
  input  logic [BITS-1:0] i_joystick1,
  input  logic [BITS-1:0] i_joystick2,
  output logic            o_frame_done,
  output logic            o_overrun,
  input  logic            i_overrun_clr
);

  localparam int c_FRAME = 2 * BITS;
  localparam int c_CW    = $clog2(c_FRAME) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_chk
    $error("joy_db15_responder: FILT_LEN must be 2..15");
  end

  // Index 0 carries joy_clk, index 1 carries joy_load.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_cond;
  logic [1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {i_joy_load, i_joy_clk};
      r_sync2 <= r_sync1;
    end
  end

`ifdef JOY_DB15_RESPONDER_FILTER_EN
  localparam logic [3:0] c_FILT_LAST = 4'(FILT_LEN - 1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic [3:0] r_cnt;
    logic       r_lvl;

    // A new level is taken only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= 4'd0;
        r_lvl <= 1'b1;
      end else if (r_sync2[gi] == r_lvl) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == c_FILT_LAST) begin
        r_lvl <= r_sync2[gi];
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end

    assign w_cond[gi] = r_lvl;
  end
`else
  assign w_cond = r_sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '1;
    end else begin
      r_prev <= w_cond;
    end
  end

  logic w_clk_rise;
  logic w_ld_low;
  logic w_ld_rise;

  assign w_clk_rise = w_cond[0] & ~r_prev[0];
  assign w_ld_low   = ~w_cond[1];
  assign w_ld_rise  = w_cond[1] & ~r_prev[1];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_shift;
  logic   w_last;
  logic   w_ovr_set;

  logic [c_FRAME-1:0] r_shreg;
  logic [c_CW-1:0]    r_cnt;
  logic               r_frame_done;
  logic               r_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A low load level overrides everything, so clock edges under load are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    w_ovr_set   = 1'b0;
    if (w_ld_low) begin
      w_state_nxt = S_LOAD;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_LOAD: begin
          if (w_ld_rise) begin
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_clk_rise) begin
            w_shift = 1'b1;
            if (r_cnt == c_LAST) begin
              w_last      = 1'b1;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_clk_rise) begin
            w_ovr_set = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg      <= '1;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (w_load) begin
        r_shreg <= ~{i_joystick2, i_joystick1};
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shreg <= {1'b1, r_shreg[c_FRAME-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Combinational so an asynchronous reset releases the line immediately.
  assign o_joy_data   = (r_state == S_LOAD || r_state == S_SHIFT) ? r_shreg[0] : 1'b1;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/joy_db15_responder.md
Name: joy_db15_responder

Overview:
- Device-side end of the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shift chain.
- Latches two players' button words when the initiator pulses JOY_LOAD, then shifts one bit per JOY_CLK rising edge onto JOY_DATA.
- Used for bench loopback against the joystick serial initiator and as a board-side emulator when a core drives a second MiSTer through the user port.

Parameters:
- BITS, 12, bits per player; frame length is 2*BITS.
- FILT_LEN, 4, stable-sample count for the input glitch filter (filter builds only; range 2..15).

Ports:
- clk  in  1  system clock (≥ 4× initiator JOY_CLK rate).
- reset_n  in  1  asynchronous, active-low reset.
- joy_clk  in  1  initiator shift clock, asynchronous to clk.
- joy_load  in  1  initiator latch strobe, active-low, asynchronous to clk.
- joy_data  out  1  serial data to initiator, active-low (0 = pressed).
- joystick1  in  BITS  player-1 buttons, active-high, sampled on latch.
- joystick2  in  BITS  player-2 buttons, active-high, sampled on latch.
- frame_done  out  1  one-clk pulse after the last frame bit is shifted.
- overrun  out  1  sticky: a shift clock arrived after the frame ended.
- overrun_clr  in  1  synchronous clear for overrun.

Behaviour:
- Reset (async, reset_n=0):
  - shift register all ones; joy_data=1; frame_done=0; overrun=0; bit counter=0; state IDLE.
  - Synchronizers preset to 1.
- Input conditioning:
  - joy_clk and joy_load each pass a 2-FF synchronizer, then a 1-cycle edge detector.
  - An edge is acted on 3 clk cycles after the pin transitions.
- Shift register:
  - Width 2*BITS, loaded with ~{joystick2, joystick1}.
  - joy_data is always bit 0, so frame order is joystick1[0..BITS-1], then joystick2[0..BITS-1].
  - Each shift moves right and fills the MSB with 1.
- States:
  - IDLE: joy_data=1, clocks ignored. Synced joy_load low → LOAD.
  - LOAD: while joy_load is low, reload the parallel words every clk (transparent, like a '165 PL). Load rising edge → SHIFT with counter=0.
  - SHIFT: each joy_clk rising edge shifts once and increments the counter. When the counter reaches 2*BITS-1 and a further edge arrives, shift, pulse frame_done for 1 cycle, and go to DONE.
  - DONE: joy_data=1. Any further joy_clk rise sets overrun (sticky). Load falling edge → LOAD.
- Precedence and boundary cases:
  - joy_load low in any state forces LOAD immediately, abandoning a partial frame. No frame_done and no overrun in that case.
  - A joy_clk rise in the same cycle as a load fall is ignored; load wins.
  - A joy_clk rise while joy_load is low is ignored.
  - overrun_clr and an overrun event in the same cycle: set wins.
  - Counter width is clog2(2*BITS)+1; it never wraps, because the state leaves SHIFT at the terminal count.
  - Parallel inputs are sampled only in LOAD. Changes mid-frame do not affect bits in flight.
  - Reset asserted mid-frame: returns to IDLE at once with joy_data=1. The first post-reset frame requires a fresh load pulse.
- Latency: joy_data reflects a new bit 3 clk cycles after each joy_clk rising edge. The initiator must sample no earlier than 4 clk cycles after its edge.

Optional Feature:
- Macro: JOY_DB15_RESPONDER_FILTER_EN.
- Defined:
  - Each synchronized input passes a debounce stage that accepts a new level only after FILT_LEN consecutive identical samples.
  - Edge latency becomes 3+FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are discarded entirely.
- Undefined: no filter; latency 3 cycles; FILT_LEN unused.

Test Plan:
- Reset, then joystick1=12'h001, joystick2=12'h800; load pulse of 8 clk, then 24 joy_clk edges at 10 clk/phase.
  - joy_data sampled after each edge reads 0,1×11 then 1×11,0 (the first bit is visible right after load rises).
  - frame_done pulses exactly once.
- Full frame done, then 2 extra joy_clk edges → joy_data stays 1 and overrun=1. overrun_clr for 1 cycle → overrun=0.
- Load pulse, 5 clocks, new load pulse with joystick1=12'hFFF → joy_data=0 for all of the next 12 bits; no frame_done before the 24th edge of the new frame; overrun=0.
- joystick1 changed from 12'h000 to 12'hFFF after bit 3 of a frame → remaining player-1 bits read 1 (released).
- reset_n low mid-frame (bit 10) → joy_data=1 within the same cycle. Clocks without a load are ignored: no frame_done, overrun=0.
- Filter builds: 2-clk glitch on joy_clk with FILT_LEN=4 → no shift. A 6-clk pulse shifts once, with edge-to-data latency 7 cycles.
